vga_port_writer: RTL and testbench
==================================

Name: vga_port_writer

Overview:
- Port-bus initiator that drives the VGA controller's port-mapped input register pair:
  - address port 40: the 4-bit memory address;
  - data port 41: the 8-bit data byte.
- Holds a 16x8 shadow buffer with one dirty bit per entry, loaded by the clock/date logic.
- Pushes dirty entries to the VGA pointer memory only while VSync is active (low), so the display never tears mid-frame.
- Replaces firmware-driven OUTPUT sequences with a hardware writer on the same Port_ID/OUT_DATA/Write_Strobe bus.

Parameters:
- ADDR_PORT, 8'd40, Port_ID value used for the address write.
- DATA_PORT, 8'd41, Port_ID value used for the data write.
- GAP_CYCLES, 1, idle bus cycles after each data write (0..3); models PicoBlaze instruction spacing.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- VSync  in  1  vertical sync from the VGA sync counters, active-low.
- load_en  in  1  write one shadow entry this cycle.
- load_addr  in  4  shadow entry index.
- load_data  in  8  shadow entry value.
- force_all  in  1  one-cycle pulse: mark all 16 entries dirty.
- Port_ID  out  8  port address to the VGA controller.
- OUT_DATA  out  8  port data, to the VGA controller's IN_DATA.
- Write_Strobe  out  1  port write strobe.
- busy  out  1  high from WR_ADDR through the end of GAP.
- done  out  1  one-cycle pulse when the last dirty entry has been sent.

Behaviour:
- Reset (RESET=0, asynchronous):
  - Port_ID=0, OUT_DATA=0, Write_Strobe=0, busy=0, done=0, state=IDLE.
  - Shadow buffer = 0; all 16 dirty bits = 1, so the first VSync window clears the VGA memory.
- All outputs are registered. Port_ID and OUT_DATA are 0 in every cycle where Write_Strobe=0.
- Shadow load: on load_en, buf[load_addr] <= load_data and dirty[load_addr] <= 1 at the clock edge. Loads are accepted in any state.
- force_all sets all dirty bits. It has priority over clearing in the same cycle.
- Selection: sel = lowest-index dirty entry (combinational priority encoder); any_dirty = OR of the dirty bits.
- FSM states: IDLE, WR_ADDR, WR_DATA, GAP.
  - IDLE: if any_dirty && VSync==0, latch cur=sel and go to WR_ADDR. Otherwise stay.
  - WR_ADDR (1 cycle): Port_ID=ADDR_PORT, OUT_DATA={4'h0,cur}, Write_Strobe=1. Go to WR_DATA.
  - WR_DATA (1 cycle): Port_ID=DATA_PORT, OUT_DATA=buf[cur] sampled at entry to this cycle, Write_Strobe=1.
    - Clear dirty[cur], unless load_en with load_addr==cur or force_all occurs in this cycle; then the bit stays set and the entry is re-sent.
    - Go to GAP if GAP_CYCLES>0.
    - If GAP_CYCLES=0, take the IDLE decision directly.
  - GAP: hold the bus idle for GAP_CYCLES cycles, then return to the IDLE decision in the same cycle. Back-to-back entries need no extra IDLE cycle.
- Per-entry bus cost = 2+GAP_CYCLES cycles. Latency from VSync falling (observed at a clock edge) to the first Write_Strobe = 1 cycle.
- Window rule:
  - A new entry starts only while VSync==0.
  - An entry already in WR_ADDR always completes WR_DATA, even if VSync rises meanwhile. A pair is never split.
  - Remaining dirty entries wait for the next VSync low.
- done pulses for one cycle on the cycle after the WR_DATA in which the dirty set became empty.
- Entries are served in ascending index order within a window. An entry loaded mid-window is still picked up in that window if VSync is low.
- Reset mid-transfer: the bus returns to idle immediately. The VGA side may hold a stale address; this is acceptable because all entries are re-sent after reset.

Test Plan:
- Post-reset clear: release RESET, hold VSync=0 for 100 cycles with GAP_CYCLES=1.
  - Expect 16 pairs in order: (40,0x00),(41,0x00) … (40,0x0F),(41,0x00).
  - Pairs 3 cycles apart; then a done pulse; then a silent bus.
- Window gating: load addr 5 = 0xA7 while VSync=1.
  - Expect no Write_Strobe.
  - On VSync falling, expect Port_ID 40/OUT_DATA 0x05, then 41/0xA7 on the next cycle; dirty[5] cleared.
- VSync rises mid-sequence: dirty {2,9}, VSync rises during WR_ADDR of entry 2.
  - Expect entry 2's data write to complete.
  - Entry 9 waits for the next VSync low.
- Collision: load_en to the address currently in WR_DATA with new value 0x3C.
  - Expect the old value on the bus this time.
  - Dirty stays set, and the entry is re-sent with 0x3C.
- force_all during an active window: pulse force_all while entry 7 is in GAP.
  - Expect the next entry sent to be 0, then the full set 0..15.
- Async reset: drop RESET during WR_DATA.
  - Expect Write_Strobe, Port_ID and OUT_DATA = 0 before the next clock edge.
  - Expect all dirty bits set afterwards.

Source files
------------

// File: rtl/vga_port_writer.sv
// vga_port_writer: hardware port-bus writer for the VGA pointer memory.
// Keeps a dirty-tracked 16x8 shadow and flushes it only while VSync is low.
module vga_port_writer #(
    parameter logic [7:0] ADDR_PORT  = 8'd40,
    parameter logic [7:0] DATA_PORT  = 8'd41,
    parameter int         GAP_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VSync,
    input  logic       load_en,
    input  logic [3:0] load_addr,
    input  logic [7:0] load_data,
    input  logic       force_all,
    output logic [7:0] Port_ID,
    output logic [7:0] OUT_DATA,
    output logic       Write_Strobe,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_GAP
    } state_t;

    localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cur;
    logic [3:0]  w_cur_nxt;
    logic [1:0]  r_gap_cnt;
    logic [1:0]  w_gap_nxt;
    logic [7:0]  r_buf [16];
    logic [15:0] r_dirty;
    logic [15:0] w_dirty_eff;
    logic [15:0] w_dirty_nxt;
    logic        w_clr;
    logic [3:0]  w_sel;
    logic        w_any;
    logic        w_start;
    logic [7:0]  w_pid_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_ws_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    // Dirty view for the serve decision: the entry finishing WR_DATA drops
    // out unless it was reloaded or force_all hit in the same cycle.
    always_comb begin
        w_clr = (r_state == S_WR_DATA)
              && !(load_en && (load_addr == r_cur))
              && !force_all;
        w_dirty_eff = r_dirty;
        if (w_clr) begin
            w_dirty_eff = r_dirty & ~(16'h0001 << r_cur);
        end
        w_dirty_nxt = w_dirty_eff;
        if (load_en) begin
            w_dirty_nxt = w_dirty_nxt | (16'h0001 << load_addr);
        end
        if (force_all) begin
            w_dirty_nxt = '1;
        end
    end

    // Lowest-index dirty entry wins, so a window serves ascending addresses.
    always_comb begin
        w_sel = '0;
        for (int i = 15; i >= 0; i--) begin
            if (w_dirty_eff[i]) begin
                w_sel = 4'(i);
            end
        end
        w_any   = |w_dirty_eff;
        w_start = w_any && !VSync;
    end

    // State register: current state, latched entry index and gap counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    // Next-state logic; a pair in flight always finishes once started.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_gap_nxt   = r_gap_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_WR_ADDR;
                    w_cur_nxt   = w_sel;
                end
            end
            S_WR_ADDR: begin
                w_state_nxt = S_WR_DATA;
            end
            S_WR_DATA: begin
                if (GAP_CYCLES > 0) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = GAP_LAST;
                end else if (w_start) begin
                    w_state_nxt = S_WR_ADDR;
                    w_cur_nxt   = w_sel;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt != 2'd0) begin
                    w_gap_nxt = r_gap_cnt - 2'd1;
                end else if (w_start) begin
                    w_state_nxt = S_WR_ADDR;
                    w_cur_nxt   = w_sel;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the bus is registered cleanly.
    always_comb begin
        w_pid_nxt  = '0;
        w_data_nxt = '0;
        w_ws_nxt   = 1'b0;
        unique case (w_state_nxt)
            S_WR_ADDR: begin
                w_pid_nxt  = ADDR_PORT;
                w_data_nxt = {4'h0, w_cur_nxt};
                w_ws_nxt   = 1'b1;
            end
            S_WR_DATA: begin
                w_pid_nxt  = DATA_PORT;
                w_data_nxt = r_buf[r_cur];
                w_ws_nxt   = 1'b1;
            end
            default: begin
                w_pid_nxt  = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_WR_DATA) && (w_dirty_nxt == '0);
    end

    // Registered bus outputs; reset drops the bus to idle at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Port_ID      <= '0;
            OUT_DATA     <= '0;
            Write_Strobe <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            Port_ID      <= w_pid_nxt;
            OUT_DATA     <= w_data_nxt;
            Write_Strobe <= w_ws_nxt;
            busy         <= w_busy_nxt;
            done         <= w_done_nxt;
        end
    end

    // Shadow buffer and dirty bits; reset marks everything dirty so the
    // first window wipes the VGA memory.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
            r_dirty <= '1;
        end else begin
            if (load_en) begin
                r_buf[load_addr] <= load_data;
            end
            r_dirty <= w_dirty_nxt;
        end
    end

endmodule

// File: tb/tb_vga_port_writer.sv
// tb_vga_port_writer: directed checks of the VGA port writer bus sequences.
// Bus writes and done pulses are logged per cycle and compared afterwards.
module tb_vga_port_writer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       VSync;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       force_all;
    logic [7:0] Port_ID;
    logic [7:0] OUT_DATA;
    logic       Write_Strobe;
    logic       busy;
    logic       done;

    typedef struct {
        int         cyc;
        logic [7:0] pid;
        logic [7:0] dat;
    } ev_t;

    ev_t        evq [$];
    int         dq [$];
    int         cyc = 0;
    int         n_total = 0;
    int         n_bad = 0;
    int         n_idle_bad = 0;
    logic [7:0] bufm [16];
    int         c0;

    vga_port_writer #(
        .ADDR_PORT (8'd40),
        .DATA_PORT (8'd41),
        .GAP_CYCLES(1)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .VSync       (VSync),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .force_all   (force_all),
        .Port_ID     (Port_ID),
        .OUT_DATA    (OUT_DATA),
        .Write_Strobe(Write_Strobe),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every bus write and done pulse mid-cycle.
    always @(negedge CLK) begin
        if (Write_Strobe) begin
            evq.push_back('{cyc: cyc, pid: Port_ID, dat: OUT_DATA});
        end else if (Port_ID != 8'd0 || OUT_DATA != 8'd0) begin
            n_idle_bad++;
        end
        if (done) dq.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
        bufm[a]   = d;
    endtask

    task automatic clr_logs();
        evq.delete();
        dq.delete();
    endtask

    task automatic chk_ev(input string tag, input int i,
                          input logic [7:0] pid, input logic [7:0] dat);
        if (i < evq.size()) begin
            chk($sformatf("%s[%0d]_pid", tag, i), evq[i].pid, pid);
            chk($sformatf("%s[%0d]_dat", tag, i), evq[i].dat, dat);
        end else begin
            chk($sformatf("%s_cnt", tag), evq.size(), i + 1);
        end
    endtask

    task automatic chk_sweep(input string tag, input int base);
        for (int k = 0; k < 16; k++) begin
            chk_ev(tag, base + 2 * k, 8'd40, 8'(k));
            chk_ev(tag, base + 2 * k + 1, 8'd41, bufm[k]);
            if (base + 2 * k + 1 < evq.size()) begin
                chk($sformatf("%s[%0d]_pair", tag, k),
                    evq[base + 2 * k + 1].cyc - evq[base + 2 * k].cyc, 1);
            end
            if (k > 0 && base + 2 * k < evq.size()) begin
                chk($sformatf("%s[%0d]_spacing", tag, k),
                    evq[base + 2 * k].cyc - evq[base + 2 * k - 2].cyc, 3);
            end
        end
    endtask

    initial begin
        RESET     = 1'b0;
        VSync     = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        force_all = 1'b0;
        for (int i = 0; i < 16; i++) bufm[i] = 8'h00;

        // reset state
        #1;
        chk("rst_pid", Port_ID, 0);
        chk("rst_dat", OUT_DATA, 0);
        chk("rst_ws", Write_Strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // post-reset clear sweep
        tick(3);
        clr_logs();
        RESET = 1'b1;
        VSync = 1'b0;
        c0 = cyc;
        tick(100);
        if (evq.size() > 0) chk("clr_latency", evq[0].cyc, c0 + 1);
        chk_sweep("clr", 0);
        chk("clr_cnt", evq.size(), 32);
        chk("clr_done_cnt", dq.size(), 1);
        if (dq.size() > 0 && evq.size() == 32) begin
            chk("clr_done_cyc", dq[0], evq[31].cyc + 1);
        end

        // window gating
        VSync = 1'b1;
        clr_logs();
        load(4'd5, 8'hA7);
        tick(10);
        chk("gate_quiet", evq.size(), 0);
        VSync = 1'b0;
        c0 = cyc;
        tick(8);
        chk_ev("gate", 0, 8'd40, 8'h05);
        chk_ev("gate", 1, 8'd41, 8'hA7);
        if (evq.size() > 1) begin
            chk("gate_lat", evq[0].cyc, c0 + 1);
            chk("gate_data_cyc", evq[1].cyc, c0 + 2);
        end
        chk("gate_cnt", evq.size(), 2);
        chk("gate_done_cnt", dq.size(), 1);

        // VSync rises during WR_ADDR of entry 2
        VSync = 1'b1;
        load(4'd2, 8'h22);
        load(4'd9, 8'h99);
        clr_logs();
        VSync = 1'b0;
        tick();
        chk("mid_ws_addr", Write_Strobe, 1);
        VSync = 1'b1;
        tick(10);
        chk_ev("mid", 0, 8'd40, 8'h02);
        chk_ev("mid", 1, 8'd41, 8'h22);
        chk("mid_cnt1", evq.size(), 2);
        VSync = 1'b0;
        tick(10);
        chk_ev("mid", 2, 8'd40, 8'h09);
        chk_ev("mid", 3, 8'd41, 8'h99);
        chk("mid_cnt2", evq.size(), 4);

        // load collides with the entry in WR_DATA
        VSync = 1'b1;
        load(4'd3, 8'h11);
        clr_logs();
        VSync = 1'b0;
        tick(2);
        chk("col_in_data", Port_ID, 8'd41);
        load(4'd3, 8'h3C);
        tick(10);
        chk_ev("col", 0, 8'd40, 8'h03);
        chk_ev("col", 1, 8'd41, 8'h11);
        chk_ev("col", 2, 8'd40, 8'h03);
        chk_ev("col", 3, 8'd41, 8'h3C);
        chk("col_cnt", evq.size(), 4);
        if (evq.size() > 2) chk("col_resend_gap", evq[2].cyc - evq[0].cyc, 3);

        // force_all while entry 7 is in GAP
        VSync = 1'b1;
        load(4'd7, 8'h77);
        clr_logs();
        VSync = 1'b0;
        tick(3);
        chk("frc_in_gap_busy", busy, 1);
        chk("frc_in_gap_ws", Write_Strobe, 0);
        force_all = 1'b1;
        tick();
        force_all = 1'b0;
        tick(70);
        chk_ev("frc", 0, 8'd40, 8'h07);
        chk_ev("frc", 1, 8'd41, 8'h77);
        chk_sweep("frc", 2);
        chk("frc_cnt", evq.size(), 34);
        chk("frc_done_cnt", dq.size(), 2);

        // async reset during WR_DATA
        VSync = 1'b1;
        load(4'd4, 8'h44);
        VSync = 1'b0;
        tick(2);
        chk("ar_pre_ws", Write_Strobe, 1);
        chk("ar_pre_pid", Port_ID, 8'd41);
        #2;
        RESET = 1'b0;
        #1;
        chk("ar_ws", Write_Strobe, 0);
        chk("ar_pid", Port_ID, 0);
        chk("ar_dat", OUT_DATA, 0);
        chk("ar_busy", busy, 0);
        for (int i = 0; i < 16; i++) bufm[i] = 8'h00;
        VSync = 1'b1;
        tick(2);
        RESET = 1'b1;
        clr_logs();
        tick(5);
        chk("ar_quiet", evq.size(), 0);
        VSync = 1'b0;
        c0 = cyc;
        tick(60);
        if (evq.size() > 0) chk("ar_latency", evq[0].cyc, c0 + 1);
        chk_sweep("ar", 0);
        chk("ar_cnt", evq.size(), 32);

        chk("idle_bus_zero", n_idle_bad, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
